// File: rtl/pulse_event_arbiter_if.sv
// ---------------------------------------------------------------------------
// pulse_event_arbiter_if
//   Bundles the event-request side and the crossing-channel side of the
//   pulse event arbiter.
//   master : event sources / supervisor. Drives req_pulse, enable and
//            drop_clr. Observes out_pulse, out_id, pending and drop.
//   slave  : the arbiter itself.
//   Signals
//     req_pulse [N_REQ]  one-cycle event strobes, one bit per source
//     enable             1 = grants allowed, 0 = hold pending events
//     drop_clr           one-cycle strobe clearing all drop bits
//     out_pulse          one-cycle pulse toward the crossing channel
//     out_id    [ID_W]   source of the most recent pulse
//     pending   [N_REQ]  latched, not-yet-issued events
//     drop      [N_REQ]  sticky lost-event flags
// ---------------------------------------------------------------------------
interface pulse_event_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req_pulse;
  logic             enable;
  logic             drop_clr;
  logic             out_pulse;
  logic [ID_W-1:0]  out_id;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] drop;

  modport master (
    output req_pulse, enable, drop_clr,
    input  out_pulse, out_id, pending, drop
  );

  modport slave (
    input  req_pulse, enable, drop_clr,
    output out_pulse, out_id, pending, drop
  );
endinterface

// File: rtl/pulse_event_arbiter.sv
// ---------------------------------------------------------------------------
// pulse_event_arbiter
//   Shares one toggle-based pulse-crossing channel between N_REQ event
//   sources. Each source's single-cycle event is latched into a pending bit,
//   a round-robin pick chooses one pending source, and a single out_pulse
//   with a stable out_id is issued. Consecutive pulses are spaced at least
//   GAP clocks apart so the slower receive domain never misses a toggle.
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : slave side of pulse_event_arbiter_if (requests, enable,
//              drop_clr in; out_pulse, out_id, pending, drop out)
// ---------------------------------------------------------------------------
module pulse_event_arbiter #(
  parameter int N_REQ = 4,
  parameter int GAP   = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pulse_event_arbiter_if.slave   bus
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(GAP + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GAP  = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_gap_cnt;
  logic [ID_W-1:0]  r_last_grant;
  logic [ID_W-1:0]  r_out_id;
  logic             r_out_pulse;
  logic [N_REQ-1:0] r_pending;
  logic [N_REQ-1:0] r_drop;

  logic             w_found;
  logic [ID_W-1:0]  w_win;
  logic             w_grant;
  logic [N_REQ-1:0] w_grant_vec;
  logic [N_REQ-1:0] w_pending_nxt;
  logic [N_REQ-1:0] w_drop_nxt;

  // Round-robin search: first set pending bit starting just above the last
  // granted source, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(r_last_grant) + i) % N_REQ;
      if (!w_found && r_pending[idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(idx);
      end
    end
  end

  // Enable only matters in IDLE; a GAP in progress always runs to the end.
  assign w_grant     = (r_state == ST_IDLE) && bus.enable && w_found;
  assign w_grant_vec = w_grant ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_win) : '0;

  // A request arriving on the cycle its pending bit is granted is queued
  // as a fresh event rather than counted as a loss.
  assign w_pending_nxt = (r_pending & ~w_grant_vec) | bus.req_pulse;
  // New drops take precedence over drop_clr in the same cycle.
  assign w_drop_nxt    = (r_drop & ~{N_REQ{bus.drop_clr}})
                       | (r_pending & bus.req_pulse & ~w_grant_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_drop    <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_drop    <= w_drop_nxt;
    end
  end

  // Grant FSM. The counter is loaded with GAP-1 on the pulse edge and the
  // FSM returns to IDLE when it reaches 1, so the next pulse can come no
  // sooner than GAP clocks after the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_gap_cnt    <= '0;
      r_last_grant <= ID_W'(N_REQ - 1);
      r_out_id     <= '0;
      r_out_pulse  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_out_pulse  <= 1'b1;
            r_out_id     <= w_win;
            r_last_grant <= w_win;
            r_gap_cnt    <= CNT_W'(GAP - 1);
            r_state      <= ST_GAP;
          end else begin
            r_out_pulse  <= 1'b0;
          end
        end
        default: begin
          r_out_pulse <= 1'b0;
          r_gap_cnt   <= r_gap_cnt - 1'b1;
          if (r_gap_cnt == CNT_W'(1)) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.out_pulse = r_out_pulse;
  assign bus.out_id    = r_out_id;
  assign bus.pending   = r_pending;
  assign bus.drop      = r_drop;

endmodule
